wrp_shff_sw_net: RTL
====================

// Module: wrp_shff_sw_net
// PURPOSE
//  Multi-lane successor of the 2:1 shuffle switch unit: one butterfly stage of 2x2 switches over NUM_LANES lanes.
//  Lane pairs (i, i+STRIDE) swap under a static or beat-counted periodic schedule, framed by s_last.
//  AXI-stream-style valid/ready on both sides; sits between FFT compute stages in the shuffle wrapper.
//  Registered output; s_ready is registered via a 2-entry skid buffer.
// PARAMETERS
//  BITWIDTH   64  width of one lane sample (bits)
//  NUM_LANES  4   lane count; power of 2, >=2
//  STRIDE     1   pair distance; power of 2, < NUM_LANES
//  PERIOD     8   beats per swap phase in periodic modes; >=1
// PORTS
//  clk       in   1                    clock, all logic on rising edge
//  rst       in   1                    synchronous, active-high reset
//  cfg_mode  in   2                    0 PASS, 1 SWAP, 2 PERIODIC, 3 PERIODIC_INV
//  s_data    in   NUM_LANES*BITWIDTH   input lanes; lane k = [k*BITWIDTH +: BITWIDTH]
//  s_last    in   1                    last beat of frame
//  s_valid   in   1                    input beat valid
//  s_ready   out  1                    input beat accepted when s_valid&s_ready
//  m_data    out  NUM_LANES*BITWIDTH   switched lanes
//  m_last    out  1                    s_last delayed with its beat
//  m_valid   out  1                    output beat valid
//  m_ready   in   1                    downstream accept
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, m_last=0, s_ready=0 while rst=1, s_ready=1 first cycle after; phase_cnt=0, mode_q=PASS.
//  Reset mid-frame: both skid entries dropped, counter and frame state cleared; no beat emitted.
//  Pair rule: for every i with (i & STRIDE)==0: swap=1 -> y[i]=x[i+STRIDE], y[i+STRIDE]=x[i]; swap=0 -> y=x.
//  Swap select per accepted beat: PASS 0; SWAP 1; PERIODIC (phase_cnt>=PERIOD); PERIODIC_INV inverse.
//  phase_cnt: 0..2*PERIOD-1, +1 per accepted beat, wraps to 0; forced to 0 after accepted beat with s_last.
//  mode_q: cfg_mode latched on the first accepted beat of each frame (phase_cnt==0 and in_frame=0), used for
//   that beat and rest of frame; cfg_mode changes mid-frame ignored. in_frame set on accept, cleared on accepted s_last.
//  Switching applied at input acceptance; data, last stored switched. Latency: accepted beat visible on
//   m_data/m_valid next cycle when output register empty or draining.
//  Skid: output reg + 1 skid entry. s_ready = !skid_full (registered). Beat accepted while output held
//   (m_valid&!m_ready) goes to skid; skid moves to output on next m_ready. Order strictly preserved.
//  Simultaneous accept in and out with skid empty: new beat loads output reg, no bubble; full throughput 1 beat/clk.
//  m_data/m_last stable while m_valid&!m_ready. No beat dropped or duplicated; s_ready never combinational on m_ready.
//  Width: no arithmetic on data; phase_cnt width $clog2(2*PERIOD), min 1.
// STRUCTURE
//  wrp_shff_pkg: mode constants (SHFF_PASS/SWAP/PER/PER_INV), cfg_mode width, lane slice helper function.
//  Sub-module wrp_shff_skid_buf (WIDTH=NUM_LANES*BITWIDTH+1): 2-entry skid register, valid/ready both sides.
//  Top: phase counter, frame/mode latch, generate loop of pair muxes feeding skid_buf.
// TESTING
//  1 Reset: rst=1 3 cycles with s_valid=1 -> m_valid=0, m_data=0, s_ready=0; s_ready=1 cycle after release.
//  2 PASS/SWAP, NUM_LANES=4 STRIDE=1, lanes {3,2,1,0}=>{D,C,B,A}: PASS -> {D,C,B,A}; SWAP -> {C,D,A,B}, 1-cycle latency.
//  3 PERIODIC PERIOD=2, 10 beats m_ready=1, no s_last -> swap pattern 0,0,1,1,0,0,1,1,0,0; every cycle m_valid=1.
//  4 Frame: PERIODIC, s_last on beat 3 -> beat 4 restarts pattern at 0; cfg_mode 2->1 at beat 2 ignored until beat 4.
//  5 Backpressure: m_ready=0 with stream on -> one beat held, one skid, s_ready=0 next cycle; m_ready=1 -> order exact, none lost.
//  6 Reset mid-frame with skid full -> m_valid=0 next cycle; next beat uses phase 0 and newly latched cfg_mode.

Source files
------------

// File: rtl/wrp_shff_sw_net_pkg.sv
// Shared definitions for the multi-lane shuffle switch: switching modes and lane addressing.
package wrp_shff_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SHFF_PASS    = 2'd0,
        SHFF_SWAP    = 2'd1,
        SHFF_PER     = 2'd2,
        SHFF_PER_INV = 2'd3
    } shff_mode_e;

    // Bit offset of lane `lane` inside a packed bus of `bw`-bit lanes.
    function automatic int lane_lo(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/wrp_shff_sw_net_if.sv
// Stream bundle (data, last, valid, ready) used on both sides of the shuffle switch.
interface wrp_shff_sw_net_if #(
    parameter int DATA_W = 256
) ();
    logic [DATA_W-1:0] data;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, output last, output valid, input ready);
    modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/wrp_shff_sw_net_skid_buf.sv
// Two-entry skid register: output register plus one overflow slot, with a registered upstream ready.
module wrp_shff_skid_buf #(
    parameter int WIDTH = 257
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_out_data,  r_out_data_next;
    logic             r_out_valid, r_out_valid_next;
    logic [WIDTH-1:0] r_skid_data, r_skid_data_next;
    logic             r_skid_valid, r_skid_valid_next;
    logic             r_in_ready;
    logic             w_in_fire;

    assign w_in_fire = i_valid & r_in_ready;

    // r_in_ready always equals !r_skid_valid once out of reset, so a new beat
    // never arrives while the skid slot is occupied.
    always_comb begin
        r_out_data_next   = r_out_data;
        r_out_valid_next  = r_out_valid;
        r_skid_data_next  = r_skid_data;
        r_skid_valid_next = r_skid_valid;
        if (!r_out_valid || i_ready) begin
            if (r_skid_valid) begin
                r_out_data_next   = r_skid_data;
                r_out_valid_next  = 1'b1;
                r_skid_valid_next = 1'b0;
            end else if (w_in_fire) begin
                r_out_data_next  = i_data;
                r_out_valid_next = 1'b1;
            end else begin
                r_out_valid_next = 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_data_next  = i_data;
            r_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_out_data   <= r_out_data_next;
            r_out_valid  <= r_out_valid_next;
            r_skid_data  <= r_skid_data_next;
            r_skid_valid <= r_skid_valid_next;
            r_in_ready   <= !r_skid_valid_next;
        end
    end

    assign o_ready = r_in_ready;
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;

endmodule

// File: rtl/wrp_shff_sw_net.sv
// One butterfly stage of 2x2 lane switches with static or periodic, frame-aligned swap schedule.
module wrp_shff_sw_net
    import wrp_shff_pkg::*;
#(
    parameter int BITWIDTH  = 64,
    parameter int NUM_LANES = 4,
    parameter int STRIDE    = 1,
    parameter int PERIOD    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] cfg_mode,
    wrp_shff_sw_net_if.slave  s,
    wrp_shff_sw_net_if.master m
);

    localparam int DATA_W = NUM_LANES * BITWIDTH;
    localparam int PH_W   = ($clog2(2 * PERIOD) < 1) ? 1 : $clog2(2 * PERIOD);

    logic [PH_W-1:0]   r_phase_cnt;
    logic              r_in_frame;
    shff_mode_e        r_mode;

    logic              w_s_ready;
    logic              w_accept;
    logic              w_frame_start;
    shff_mode_e        w_mode;
    logic              w_per_hi;
    logic              w_swap;
    logic [DATA_W-1:0] w_sw_data;
    logic [DATA_W:0]   w_out;

    assign w_accept      = s.valid & w_s_ready;
    assign w_frame_start = !r_in_frame && (r_phase_cnt == '0);
    // The first beat of a frame uses the live cfg_mode; later beats use the latched copy.
    assign w_mode        = w_frame_start ? shff_mode_e'(cfg_mode) : r_mode;
    assign w_per_hi      = (r_phase_cnt >= PH_W'(PERIOD));

    always_comb begin
        w_swap = 1'b0;
        case (w_mode)
            SHFF_PASS:    w_swap = 1'b0;
            SHFF_SWAP:    w_swap = 1'b1;
            SHFF_PER:     w_swap = w_per_hi;
            SHFF_PER_INV: w_swap = !w_per_hi;
            default:      w_swap = 1'b0;
        endcase
    end

    // Partner of lane gi is gi ^ STRIDE since STRIDE is a single bit.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam int LO   = lane_lo(gi, BITWIDTH);
            localparam int P_LO = lane_lo(gi ^ STRIDE, BITWIDTH);
            assign w_sw_data[LO +: BITWIDTH] = w_swap ? s.data[P_LO +: BITWIDTH]
                                                      : s.data[LO +: BITWIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_cnt <= '0;
            r_in_frame  <= 1'b0;
            r_mode      <= SHFF_PASS;
        end else if (w_accept) begin
            if (w_frame_start) begin
                r_mode <= w_mode;
            end
            r_in_frame <= !s.last;
            if (s.last || (r_phase_cnt == PH_W'(2 * PERIOD - 1))) begin
                r_phase_cnt <= '0;
            end else begin
                r_phase_cnt <= r_phase_cnt + 1'b1;
            end
        end
    end

    wrp_shff_skid_buf #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({s.last, w_sw_data}),
        .i_valid (s.valid),
        .o_ready (w_s_ready),
        .o_data  (w_out),
        .o_valid (m.valid),
        .i_ready (m.ready)
    );

    assign s.ready = w_s_ready;
    assign m.data  = w_out[DATA_W-1:0];
    assign m.last  = w_out[DATA_W];

endmodule
